// File: rtl/cmb_sweep_pkg.sv
// Shared state type, MISR defaults and the MISR step function for the
// combinational sweep self-test.
package cmb_sweep_pkg;

    localparam int unsigned MISR_W = 10;

    localparam logic [MISR_W-1:0] MISR_POLY_DEF = 10'h009;
    localparam logic [MISR_W-1:0] MISR_SEED_DEF = 10'h200;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_REPORT  = 2'd3
    } sweep_state_e;

    // Galois shift: the bit leaving the top folds back through the taps.
    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] misr,
        input logic [MISR_W-1:0] poly,
        input logic [MISR_W-1:0] din
    );
        return {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? poly : '0) ^ din;
    endfunction

endpackage

// File: rtl/cmb_sweep_bist_misr.sv
// Signature compaction register for the sweep self-test: load seed, step
// with a response word, or hold.
module sweep_misr
    import cmb_sweep_pkg::*;
#(
    parameter logic [MISR_W-1:0] POLY = MISR_POLY_DEF,
    parameter logic [MISR_W-1:0] SEED = MISR_SEED_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [MISR_W-1:0] din_i,
    output logic [MISR_W-1:0] misr_o
);

    logic [MISR_W-1:0] misr_q;
    logic [MISR_W-1:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (load_i) begin
            misr_d = SEED;
        end else if (step_i) begin
            misr_d = misr_step(misr_q, POLY, din_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign misr_o = misr_q;

endmodule

// File: rtl/cmb_sweep_bist.sv
// Exhaustive-sweep self-test controller: walks every input vector through the
// function under test, compacts responses into a MISR and reports pass/fail.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | func_in parked at 0, waiting for start
//   ST_WAIT    | current vector on func_in, settle counter running down
//   ST_CAPTURE | response compacted into the MISR, advance or finish
//   ST_REPORT  | signature/pass presented until the logger accepts
module cmb_sweep_bist
    import cmb_sweep_pkg::*;
#(
    parameter int unsigned       IN_W      = 7,
    parameter int unsigned       OUT_W     = MISR_W,
    parameter int unsigned       SETTLE    = 1,
    parameter logic [OUT_W-1:0]  MISR_POLY = MISR_POLY_DEF,
    parameter logic [OUT_W-1:0]  MISR_SEED = MISR_SEED_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [OUT_W-1:0]  golden_i,
    output logic [IN_W-1:0]   func_in_o,
    input  logic [OUT_W-1:0]  func_out_i,
    output logic              busy_o,
    output logic              sig_valid_o,
    input  logic              sig_ready_i,
    output logic [OUT_W-1:0]  signature_o,
    output logic              pass_o,
    output logic              done_o,
    output logic              aborted_o
);

    localparam logic [3:0]  SETTLE_RL = 4'(SETTLE - 1);
    localparam logic [IN_W:0] LAST_VEC = {1'b0, {IN_W{1'b1}}};

    sweep_state_e      state_q;
    logic [IN_W:0]     vec_q;
    logic [IN_W:0]     vec_d;
    logic [3:0]        settle_q;
    logic [OUT_W-1:0]  golden_q;
    logic [IN_W-1:0]   func_in_q;
    logic              busy_q;
    logic              sig_valid_q;
    logic              pass_q;
    logic              done_q;
    logic              aborted_q;

    logic              misr_load;
    logic              misr_stepen;
    logic [OUT_W-1:0]  misr_cur;
    logic [OUT_W-1:0]  misr_nxt;

    assign vec_d       = vec_q + 1'b1;
    assign misr_load   = (state_q == ST_IDLE) && start_i && !abort_i;
    assign misr_stepen = (state_q == ST_CAPTURE) && !abort_i;
    assign misr_nxt    = misr_step(misr_cur, MISR_POLY, func_out_i);

    sweep_misr #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (misr_load),
        .step_i (misr_stepen),
        .din_i  (func_out_i),
        .misr_o (misr_cur)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            settle_q    <= '0;
            golden_q    <= '0;
            func_in_q   <= '0;
            busy_q      <= 1'b0;
            sig_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            // Abort outranks every other event once a sweep is running.
            if ((state_q != ST_IDLE) && abort_i) begin
                state_q     <= ST_IDLE;
                func_in_q   <= '0;
                busy_q      <= 1'b0;
                sig_valid_q <= 1'b0;
                pass_q      <= 1'b0;
                aborted_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            state_q   <= ST_WAIT;
                            vec_q     <= '0;
                            settle_q  <= SETTLE_RL;
                            golden_q  <= golden_i;
                            func_in_q <= '0;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (settle_q == 4'd0) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            settle_q <= settle_q - 4'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        if (vec_q == LAST_VEC) begin
                            state_q     <= ST_REPORT;
                            sig_valid_q <= 1'b1;
                            pass_q      <= (misr_nxt == golden_q);
                        end else begin
                            state_q   <= ST_WAIT;
                            vec_q     <= vec_d;
                            func_in_q <= vec_d[IN_W-1:0];
                            settle_q  <= SETTLE_RL;
                        end
                    end
                    ST_REPORT: begin
                        if (sig_ready_i) begin
                            state_q     <= ST_IDLE;
                            func_in_q   <= '0;
                            busy_q      <= 1'b0;
                            sig_valid_q <= 1'b0;
                            pass_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign func_in_o   = func_in_q;
    assign busy_o      = busy_q;
    assign sig_valid_o = sig_valid_q;
    assign signature_o = misr_cur;
    assign pass_o      = pass_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_cmb_sweep_bist.sv
// Directed/randomized bench for cmb_sweep_bist: one default instance and one
// with a longer settle and a zero seed, checked against a sweep-level model.
module tb_cmb_sweep_bist;
    import cmb_sweep_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start_a, abort_a, sig_ready_a;
    logic [9:0] golden_a, func_out_a, signature_a;
    logic [6:0] func_in_a;
    logic       busy_a, sig_valid_a, pass_a, done_a, aborted_a;

    logic       start_b, abort_b, sig_ready_b;
    logic [9:0] golden_b, func_out_b, signature_b;
    logic [6:0] func_in_b;
    logic       busy_b, sig_valid_b, pass_b, done_b, aborted_b;

    int         fo_mode_a, fo_mode_b;
    logic [9:0] tbl [128];
    int         errors = 0;
    int         checks = 0;

    cmb_sweep_bist u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
        .golden_i(golden_a), .func_in_o(func_in_a), .func_out_i(func_out_a),
        .busy_o(busy_a), .sig_valid_o(sig_valid_a), .sig_ready_i(sig_ready_a),
        .signature_o(signature_a), .pass_o(pass_a), .done_o(done_a),
        .aborted_o(aborted_a)
    );

    cmb_sweep_bist #(.SETTLE(3), .MISR_SEED(10'h000)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
        .golden_i(golden_b), .func_in_o(func_in_b), .func_out_i(func_out_b),
        .busy_o(busy_b), .sig_valid_o(sig_valid_b), .sig_ready_i(sig_ready_b),
        .signature_o(signature_b), .pass_o(pass_b), .done_o(done_b),
        .aborted_o(aborted_b)
    );

    // Response of the stubbed function block for vector v.
    function automatic logic [9:0] resp(input int mode, input int v);
        case (mode)
            0:       return 10'd0;
            1:       return 10'(v);
            default: return tbl[v];
        endcase
    endfunction

    // Expected signature after folding all 128 responses into the seed.
    function automatic logic [9:0] model(input logic [9:0] seed, input int mode);
        logic [9:0] m;
        m = seed;
        for (int v = 0; v < 128; v++) m = misr_step(m, MISR_POLY_DEF, resp(mode, v));
        return m;
    endfunction

    always_comb func_out_a = resp(fo_mode_a, int'(func_in_a));
    always_comb func_out_b = resp(fo_mode_b, int'(func_in_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_a(input logic [9:0] gold, input bit spam,
                           output int cyc, output logic [9:0] first_sig);
        golden_a = gold;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        golden_a = 10'($urandom);
        check("a_busy_after_start", busy_a, 1);
        check("a_seed_loaded", signature_a, MISR_SEED_DEF);
        cyc = 1;
        first_sig = '0;
        while (!sig_valid_a && cyc < 1000) begin
            if (spam) start_a = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (cyc == 3) first_sig = signature_a;
        end
        start_a = 1'b0;
    endtask

    task automatic hs_a();
        logic [9:0] sig;
        sig = signature_a;
        sig_ready_a = 1'b1;
        tick();
        sig_ready_a = 1'b0;
        check("a_done_pulse", done_a, 1);
        check("a_busy_fall_on_hs", busy_a, 0);
        check("a_valid_clear", sig_valid_a, 0);
        check("a_pass_clear", pass_a, 0);
        check("a_sig_kept", signature_a, sig);
        tick();
        check("a_done_one_cycle", done_a, 0);
    endtask

    task automatic hs_b();
        sig_ready_b = 1'b1;
        tick();
        sig_ready_b = 1'b0;
        check("b_done_pulse", done_b, 1);
        check("b_busy_fall_on_hs", busy_b, 0);
        tick();
    endtask

    initial begin
        int cyc, bad, cnt;
        logic [9:0] first_sig, gold, sig_hold, m, p, d, ref_v;
        bit pass_hold;

        for (int i = 0; i < 128; i++) tbl[i] = 10'($urandom);
        fo_mode_a = 0; fo_mode_b = 0;
        start_a = 0; abort_a = 0; sig_ready_a = 0; golden_a = 0;
        start_b = 0; abort_b = 0; sig_ready_b = 0; golden_b = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_func_in", func_in_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_sig_valid", sig_valid_a, 0);
        check("rst_signature", signature_a, 10'h200);
        check("rst_pass", pass_a, 0);
        check("rst_done", done_a, 0);
        check("rst_aborted", aborted_a, 0);
        check("rst_signature_b", signature_b, 10'h000);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            m = 10'($urandom); p = 10'($urandom); d = 10'($urandom);
            ref_v = 10'((32'(m) * 2) % 1024) ^ ((m >= 10'd512) ? p : 10'd0) ^ d;
            check("pkg_misr_step", misr_step(m, p, d), ref_v);
        end

        // Zero response, default seed, wrong golden; hold ready low in REPORT.
        gold = model(10'h200, 0) ^ 10'h001;
        sweep_a(gold, 1'b0, cyc, first_sig);
        check("a_valid_latency", cyc, 257);
        check("a_first_capture", first_sig, 10'h009);
        check("a_zero_signature", signature_a, model(10'h200, 0));
        check("a_zero_pass_bad_golden", pass_a, 0);
        sig_hold = signature_a;
        pass_hold = pass_a;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("a_hold_signature", signature_a, sig_hold);
            check("a_hold_pass", pass_a, pass_hold);
            check("a_hold_valid", sig_valid_a, 1);
        end
        hs_a();

        // Random response table, correct golden.
        fo_mode_a = 2;
        sweep_a(model(10'h200, 2), 1'b0, cyc, first_sig);
        check("a_rand_latency", cyc, 257);
        check("a_rand_signature", signature_a, model(10'h200, 2));
        check("a_rand_pass", pass_a, 1);
        hs_a();

        // Identity response with SETTLE=3 on the second instance.
        fo_mode_b = 1;
        golden_b = model(10'h000, 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        golden_b = '0;
        bad = 0;
        for (int v = 0; v < 128; v++) begin
            for (int k = 0; k < 4; k++) begin
                if (func_in_b !== 7'(v) || sig_valid_b !== 1'b0) bad++;
                tick();
            end
        end
        check("b_func_in_steps", bad, 0);
        check("b_valid_after_513", sig_valid_b, 1);
        check("b_ident_signature", signature_b, model(10'h000, 1));
        check("b_ident_pass", pass_b, 1);
        hs_b();

        // Zero response, zero seed, zero golden.
        fo_mode_b = 0;
        golden_b = '0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 1;
        while (!sig_valid_b && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("b_zero_latency", cyc, 513);
        check("b_zero_signature", signature_b, 10'h000);
        check("b_zero_pass", pass_b, 1);
        hs_b();

        // Abort while vector 40 is settling.
        golden_a = '0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cnt = 0;
        while (func_in_a !== 7'd40 && cnt < 1000) begin
            tick();
            cnt++;
        end
        check("a_reach_vec40", func_in_a, 40);
        sig_hold = signature_a;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_pulse", aborted_a, 1);
        check("abort_busy", busy_a, 0);
        check("abort_func_in", func_in_a, 0);
        check("abort_no_valid", sig_valid_a, 0);
        check("abort_misr_frozen", signature_a, sig_hold);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (aborted_a || sig_valid_a || done_a || busy_a) cnt++;
        end
        check("abort_quiet_after", cnt, 0);
        sweep_a(model(10'h200, 2), 1'b0, cyc, first_sig);
        check("restart_latency", cyc, 257);
        check("restart_signature", signature_a, model(10'h200, 2));
        check("restart_pass", pass_a, 1);
        hs_a();

        // Asynchronous reset while vector 5 is settling.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cnt = 0;
        while (func_in_a !== 7'd5 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("a_reach_vec5", func_in_a, 5);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_func_in", func_in_a, 0);
        check("arst_signature", signature_a, 10'h200);
        check("arst_valid_pass", {sig_valid_a, pass_a, done_a, aborted_a}, 0);
        #1 rst_n = 1'b1;
        tick(); tick();
        check("arst_no_autostart", busy_a, 0);

        // start and abort together in IDLE.
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("idle_abort_beats_start", busy_a, 0);
        check("idle_abort_no_pulse", aborted_a, 0);
        tick();
        check("idle_abort_still_idle", busy_a, 0);

        // Random start pulses while busy must not disturb timing.
        sweep_a(model(10'h200, 2), 1'b1, cyc, first_sig);
        check("spam_latency", cyc, 257);
        check("spam_signature", signature_a, model(10'h200, 2));
        check("spam_pass", pass_a, 1);
        hs_a();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
